// File: rtl/multicycle_control_pkg.sv
// Shared constants and types for the multi-cycle MIPS control sequencer:
// opcodes, ALUOp codes, FSM states, opcode classes and the control word.
package mips_ctrl_pkg;

   localparam logic [5:0] OP_R    = 6'h00;
   localparam logic [5:0] OP_ADDI = 6'h08;
   localparam logic [5:0] OP_ORI  = 6'h0D;
   localparam logic [5:0] OP_ANDI = 6'h0C;
   localparam logic [5:0] OP_BEQ  = 6'h04;
   localparam logic [5:0] OP_BNE  = 6'h05;
   localparam logic [5:0] OP_J    = 6'h02;
   localparam logic [5:0] OP_JAL  = 6'h03;
   localparam logic [5:0] OP_LUI  = 6'h0F;
   localparam logic [5:0] OP_LW   = 6'h23;
   localparam logic [5:0] OP_SW   = 6'h2B;

   localparam logic [2:0] ALU_R    = 3'b111;
   localparam logic [2:0] ALU_ADD  = 3'b100;
   localparam logic [2:0] ALU_OR   = 3'b101;
   localparam logic [2:0] ALU_AND  = 3'b000;
   localparam logic [2:0] ALU_SUB  = 3'b001;
   localparam logic [2:0] ALU_LUI  = 3'b010;
   localparam logic [2:0] ALU_LDST = 3'b110;
   localparam logic [2:0] ALU_JAL  = 3'b011;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
      S_R_EXEC, S_I_EXEC, S_ALU_WB, S_BRANCH, S_JUMP, S_ILLEGAL
   } state_t;

   typedef enum logic [3:0] {
      CL_R, CL_ADDI, CL_ORI, CL_ANDI, CL_LUI, CL_LW, CL_SW,
      CL_BEQ, CL_BNE, CL_J, CL_JAL, CL_ILL
   } opClass_t;

   typedef struct packed {
      logic       PCWrite;
      logic       IorD;
      logic       MemRead;
      logic       MemWrite;
      logic       IRWrite;
      logic       RegDst;
      logic       MemtoReg;
      logic       RegWrite;
      logic       Jal;
      logic       ALUSrcA;
      logic [1:0] ALUSrcB;
      logic [2:0] ALUOp;
      logic [1:0] PCSource;
      logic       InstrDone;
   } ctrlWord_t;

   function automatic opClass_t classify(input logic [5:0] op);
      opClass_t cls;
      case (op)
         OP_R:    cls = CL_R;
         OP_ADDI: cls = CL_ADDI;
         OP_ORI:  cls = CL_ORI;
         OP_ANDI: cls = CL_ANDI;
         OP_LUI:  cls = CL_LUI;
         OP_LW:   cls = CL_LW;
         OP_SW:   cls = CL_SW;
         OP_BEQ:  cls = CL_BEQ;
         OP_BNE:  cls = CL_BNE;
         OP_J:    cls = CL_J;
         OP_JAL:  cls = CL_JAL;
         default: cls = CL_ILL;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Opcode/status inputs and datapath control outputs of the sequencer.
// master = the controller, slave = the datapath side.
interface multicycle_control_if;
   logic [5:0] OP;
   logic       Zero;
   logic       mem_ready;
   logic       PCWrite;
   logic       IorD;
   logic       MemRead;
   logic       MemWrite;
   logic       IRWrite;
   logic       RegDst;
   logic       MemtoReg;
   logic       RegWrite;
   logic       Jal;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [2:0] ALUOp;
   logic [1:0] PCSource;
   logic       InstrDone;
   logic       IllegalOp;

   modport master (
      input  OP, Zero, mem_ready,
      output PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
             RegWrite, Jal, ALUSrcA, ALUSrcB, ALUOp, PCSource, InstrDone, IllegalOp
   );

   modport slave (
      output OP, Zero, mem_ready,
      input  PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
             RegWrite, Jal, ALUSrcA, ALUSrcB, ALUOp, PCSource, InstrDone, IllegalOp
   );
endinterface

// File: rtl/multicycle_control_state_decode.sv
// Combinational decode of FSM state and latched opcode class into the
// datapath control word, including Zero and mem_ready gating.
module ctrl_state_decode
   import mips_ctrl_pkg::*;
(
   input  state_t    state,
   input  opClass_t  opClass,
   input  logic      zero,
   input  logic      memReady,
   output ctrlWord_t ctrlWord
);

   // Control word per state; every unlisted field stays zero.
   always_comb begin
      ctrlWord = '0;
      case (state)
         S_FETCH: begin
            ctrlWord.MemRead = 1'b1;
            ctrlWord.ALUSrcB = 2'b01;
            ctrlWord.ALUOp   = ALU_ADD;
            ctrlWord.IRWrite = memReady;
            ctrlWord.PCWrite = memReady;
         end
         S_DECODE: begin
            ctrlWord.ALUSrcB = 2'b11;
            ctrlWord.ALUOp   = ALU_ADD;
         end
         S_MEM_ADDR: begin
            ctrlWord.ALUSrcA = 1'b1;
            ctrlWord.ALUSrcB = 2'b10;
            ctrlWord.ALUOp   = ALU_LDST;
         end
         S_MEM_READ: begin
            ctrlWord.MemRead = 1'b1;
            ctrlWord.IorD    = 1'b1;
         end
         S_MEM_WB: begin
            ctrlWord.RegWrite  = 1'b1;
            ctrlWord.MemtoReg  = 1'b1;
            ctrlWord.InstrDone = 1'b1;
         end
         S_MEM_WRITE: begin
            ctrlWord.MemWrite  = 1'b1;
            ctrlWord.IorD      = 1'b1;
            ctrlWord.InstrDone = memReady;
         end
         S_R_EXEC: begin
            ctrlWord.ALUSrcA = 1'b1;
            ctrlWord.ALUOp   = ALU_R;
         end
         S_I_EXEC: begin
            ctrlWord.ALUSrcA = 1'b1;
            ctrlWord.ALUSrcB = 2'b10;
            case (opClass)
               CL_ORI:  ctrlWord.ALUOp = ALU_OR;
               CL_ANDI: ctrlWord.ALUOp = ALU_AND;
               CL_LUI:  ctrlWord.ALUOp = ALU_LUI;
               default: ctrlWord.ALUOp = ALU_ADD;
            endcase
         end
         S_ALU_WB: begin
            ctrlWord.RegWrite  = 1'b1;
            ctrlWord.RegDst    = (opClass == CL_R);
            ctrlWord.InstrDone = 1'b1;
         end
         S_BRANCH: begin
            ctrlWord.ALUSrcA   = 1'b1;
            ctrlWord.ALUOp     = ALU_SUB;
            ctrlWord.PCSource  = 2'b01;
            ctrlWord.PCWrite   = (opClass == CL_BNE) ? ~zero : zero;
            ctrlWord.InstrDone = 1'b1;
         end
         S_JUMP: begin
            ctrlWord.PCSource  = 2'b10;
            ctrlWord.PCWrite   = 1'b1;
            ctrlWord.InstrDone = 1'b1;
            ctrlWord.RegWrite  = (opClass == CL_JAL);
            ctrlWord.Jal       = (opClass == CL_JAL);
            ctrlWord.ALUOp     = (opClass == CL_JAL) ? ALU_JAL : 3'b000;
         end
         S_ILLEGAL: begin
            ctrlWord.InstrDone = 1'b1;
         end
         default: ctrlWord = '0;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: state register, opcode-class latch,
// sticky illegal-opcode flag and next-state logic.
module multicycle_control
   import mips_ctrl_pkg::*;
(
   input logic             clk,
   input logic             reset,
   multicycle_control_if.master bus
);

   state_t    state_r;
   state_t    nextState_s;
   opClass_t  opClass_r;
   opClass_t  decodeClass_s;
   logic      illegal_r;
   ctrlWord_t word_s;

   assign decodeClass_s = classify(bus.OP);

   // State register, opcode-class latch (DECODE only) and sticky illegal flag.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r   <= S_FETCH;
         opClass_r <= CL_ILL;
         illegal_r <= 1'b0;
      end else begin
         state_r <= nextState_s;
         if (state_r == S_DECODE) begin
            opClass_r <= decodeClass_s;
         end
         if (state_r == S_ILLEGAL) begin
            illegal_r <= 1'b1;
         end
      end
   end

   // Next-state sequencing; memory states hold until mem_ready.
   always_comb begin
      nextState_s = S_FETCH;
      case (state_r)
         S_FETCH:     nextState_s = bus.mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (decodeClass_s)
               CL_R:                             nextState_s = S_R_EXEC;
               CL_ADDI, CL_ORI, CL_ANDI, CL_LUI: nextState_s = S_I_EXEC;
               CL_LW, CL_SW:                     nextState_s = S_MEM_ADDR;
               CL_BEQ, CL_BNE:                   nextState_s = S_BRANCH;
               CL_J, CL_JAL:                     nextState_s = S_JUMP;
               default:                          nextState_s = S_ILLEGAL;
            endcase
         end
         S_MEM_ADDR:  nextState_s = (opClass_r == CL_SW) ? S_MEM_WRITE : S_MEM_READ;
         S_MEM_READ:  nextState_s = bus.mem_ready ? S_MEM_WB : S_MEM_READ;
         S_MEM_WRITE: nextState_s = bus.mem_ready ? S_FETCH : S_MEM_WRITE;
         S_R_EXEC:    nextState_s = S_ALU_WB;
         S_I_EXEC:    nextState_s = S_ALU_WB;
         default:     nextState_s = S_FETCH;
      endcase
   end

   ctrl_state_decode uDecode (
      .state    (state_r),
      .opClass  (opClass_r),
      .zero     (bus.Zero),
      .memReady (bus.mem_ready),
      .ctrlWord (word_s)
   );

   // Reset low forces every output to zero in the same cycle, not just after the edge.
   assign bus.PCWrite   = reset & word_s.PCWrite;
   assign bus.IorD      = reset & word_s.IorD;
   assign bus.MemRead   = reset & word_s.MemRead;
   assign bus.MemWrite  = reset & word_s.MemWrite;
   assign bus.IRWrite   = reset & word_s.IRWrite;
   assign bus.RegDst    = reset & word_s.RegDst;
   assign bus.MemtoReg  = reset & word_s.MemtoReg;
   assign bus.RegWrite  = reset & word_s.RegWrite;
   assign bus.Jal       = reset & word_s.Jal;
   assign bus.ALUSrcA   = reset & word_s.ALUSrcA;
   assign bus.ALUSrcB   = reset ? word_s.ALUSrcB  : 2'b00;
   assign bus.ALUOp     = reset ? word_s.ALUOp    : 3'b000;
   assign bus.PCSource  = reset ? word_s.PCSource : 2'b00;
   assign bus.InstrDone = reset & word_s.InstrDone;
   assign bus.IllegalOp = reset & illegal_r;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench: per-cycle expected control words are queued while the
// instruction stream is built, then popped and compared as the DUT runs.
module tb_multicycle_control;
   import mips_ctrl_pkg::*;

   localparam int ST_F = 0, ST_D = 1, ST_MA = 2, ST_MR = 3, ST_MWB = 4, ST_MW = 5;
   localparam int ST_REX = 6, ST_IEX = 7, ST_AWB = 8, ST_BR = 9, ST_JMP = 10, ST_ILL = 11;

   typedef struct packed {
      logic        rstv;
      logic [5:0]  op;
      logic        zero;
      logic        rdy;
      logic [18:0] exp;
   } cyc_t;

   logic clk;
   logic reset;
   multicycle_control_if bus ();

   multicycle_control dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   cyc_t  cycQ[$];
   string tagQ[$];
   int    errCnt   = 0;
   int    checkCnt = 0;
   int    expDone  = 0;
   int    obsDone  = 0;
   bit    illFlag  = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCnt++;
      if (obs !== exp) begin
         errCnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference control word packed as
   // {PCWrite,IorD,MemRead,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,Jal,ALUSrcA,ALUSrcB,ALUOp,PCSource,InstrDone,IllegalOp}
   function automatic logic [18:0] expWord(input int st, input logic [5:0] op,
                                           input logic zero, input logic rdy, input logic ill);
      logic pcw = 1'b0, iord = 1'b0, mrd = 1'b0, mwr = 1'b0, irw = 1'b0, rdst = 1'b0;
      logic m2r = 1'b0, rw = 1'b0, jal = 1'b0, srca = 1'b0, done = 1'b0;
      logic [1:0] srcb = 2'b00, pcs = 2'b00;
      logic [2:0] aop = 3'b000;
      case (st)
         ST_F:   begin mrd = 1'b1; srcb = 2'b01; aop = 3'b100; irw = rdy; pcw = rdy; end
         ST_D:   begin srcb = 2'b11; aop = 3'b100; end
         ST_MA:  begin srca = 1'b1; srcb = 2'b10; aop = 3'b110; end
         ST_MR:  begin mrd = 1'b1; iord = 1'b1; end
         ST_MWB: begin rw = 1'b1; m2r = 1'b1; done = 1'b1; end
         ST_MW:  begin mwr = 1'b1; iord = 1'b1; done = rdy; end
         ST_REX: begin srca = 1'b1; srcb = 2'b00; aop = 3'b111; end
         ST_IEX: begin
            srca = 1'b1; srcb = 2'b10;
            aop = (op == 6'h0D) ? 3'b101 : (op == 6'h0C) ? 3'b000 : (op == 6'h0F) ? 3'b010 : 3'b100;
         end
         ST_AWB: begin rw = 1'b1; rdst = (op == 6'h00); done = 1'b1; end
         ST_BR:  begin
            srca = 1'b1; aop = 3'b001; pcs = 2'b01; done = 1'b1;
            pcw = (op == 6'h04) ? zero : ~zero;
         end
         ST_JMP: begin
            pcs = 2'b10; pcw = 1'b1; done = 1'b1;
            if (op == 6'h03) begin rw = 1'b1; jal = 1'b1; aop = 3'b011; end
         end
         ST_ILL: done = 1'b1;
         default: done = 1'b0;
      endcase
      return {pcw, iord, mrd, mwr, irw, rdst, m2r, rw, jal, srca, srcb, aop, pcs, done, ill};
   endfunction

   task automatic pushCycle(input string tag, input int st, input logic [5:0] op,
                            input logic zero, input logic rdy, input logic rstv);
      cyc_t c;
      c.rstv = rstv;
      c.op   = (st == ST_D) ? op : 6'($urandom_range(0, 63));
      c.zero = (st == ST_BR) ? zero : 1'($urandom_range(0, 1));
      c.rdy  = rdy;
      c.exp  = rstv ? expWord(st, op, zero, rdy, illFlag) : 19'd0;
      if (!rstv) illFlag = 1'b0;
      else if (st == ST_ILL) illFlag = 1'b1;
      cycQ.push_back(c);
      tagQ.push_back(tag);
   endtask

   task automatic queueReset(input int n);
      for (int i = 0; i < n; i++) pushCycle($sformatf("reset.c%0d", i + 1), ST_F, 6'h00, 1'b0,
                                            1'($urandom_range(0, 1)), 1'b0);
   endtask

   // trunc < 0 queues the whole instruction; otherwise only its first trunc cycles.
   task automatic queueInstr(input string name, input logic [5:0] op, input logic zero,
                             input int fStall, input int mStall, input int trunc);
      int sts[$];
      bit rdys[$];
      for (int i = 0; i < fStall; i++) begin sts.push_back(ST_F); rdys.push_back(1'b0); end
      sts.push_back(ST_F); rdys.push_back(1'b1);
      sts.push_back(ST_D); rdys.push_back(1'($urandom_range(0, 1)));
      case (op)
         6'h23: begin
            sts.push_back(ST_MA); rdys.push_back(1'($urandom_range(0, 1)));
            for (int i = 0; i < mStall; i++) begin sts.push_back(ST_MR); rdys.push_back(1'b0); end
            sts.push_back(ST_MR); rdys.push_back(1'b1);
            sts.push_back(ST_MWB); rdys.push_back(1'($urandom_range(0, 1)));
         end
         6'h2B: begin
            sts.push_back(ST_MA); rdys.push_back(1'($urandom_range(0, 1)));
            for (int i = 0; i < mStall; i++) begin sts.push_back(ST_MW); rdys.push_back(1'b0); end
            sts.push_back(ST_MW); rdys.push_back(1'b1);
         end
         6'h00: begin
            sts.push_back(ST_REX); rdys.push_back(1'b0);
            sts.push_back(ST_AWB); rdys.push_back(1'b1);
         end
         6'h08, 6'h0D, 6'h0C, 6'h0F: begin
            sts.push_back(ST_IEX); rdys.push_back(1'b0);
            sts.push_back(ST_AWB); rdys.push_back(1'b0);
         end
         6'h04, 6'h05: begin sts.push_back(ST_BR);  rdys.push_back(1'($urandom_range(0, 1))); end
         6'h02, 6'h03: begin sts.push_back(ST_JMP); rdys.push_back(1'($urandom_range(0, 1))); end
         default:      begin sts.push_back(ST_ILL); rdys.push_back(1'($urandom_range(0, 1))); end
      endcase
      for (int i = 0; i < sts.size() && (trunc < 0 || i < trunc); i++)
         pushCycle($sformatf("%s.c%0d", name, i + 1), sts[i], op, zero, rdys[i], 1'b1);
      if (trunc < 0) expDone++;
   endtask

   function automatic logic [18:0] obsWord();
      return {bus.PCWrite, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite, bus.RegDst,
              bus.MemtoReg, bus.RegWrite, bus.Jal, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp,
              bus.PCSource, bus.InstrDone, bus.IllegalOp};
   endfunction

   initial begin
      cyc_t  c;
      string tag;
      reset         = 1'b0;
      bus.OP        = 6'h00;
      bus.Zero      = 1'b0;
      bus.mem_ready = 1'b1;

      queueReset(2);
      queueInstr("LW",    6'h23, 1'b0, 0, 0, -1);
      queueInstr("SW",    6'h2B, 1'b0, 0, 3, -1);
      queueInstr("BEQ",   6'h04, 1'b1, 0, 0, -1);
      queueInstr("BNE",   6'h05, 1'b1, 0, 0, -1);
      queueInstr("BEQ0",  6'h04, 1'b0, 0, 0, -1);
      queueInstr("BNE0",  6'h05, 1'b0, 0, 0, -1);
      queueInstr("JAL",   6'h03, 1'b0, 0, 0, -1);
      queueInstr("J",     6'h02, 1'b0, 0, 0, -1);
      queueInstr("R",     6'h00, 1'b0, 0, 0, -1);
      queueInstr("ADDI",  6'h08, 1'b0, 0, 0, -1);
      queueInstr("ORI",   6'h0D, 1'b0, 0, 0, -1);
      queueInstr("ANDI",  6'h0C, 1'b0, 0, 0, -1);
      queueInstr("LUI",   6'h0F, 1'b0, 0, 0, -1);
      queueInstr("LWst",  6'h23, 1'b0, 2, 2, -1);
      queueInstr("ILL",   6'h3F, 1'b0, 0, 0, -1);
      queueInstr("LWabt", 6'h23, 1'b0, 0, 0, 2);
      queueReset(1);
      queueInstr("Rpost", 6'h00, 1'b0, 0, 0, -1);
      queueInstr("SWpost", 6'h2B, 1'b0, 1, 0, -1);

      while (cycQ.size() > 0) begin
         c   = cycQ.pop_front();
         tag = tagQ.pop_front();
         @(posedge clk);
         #1;
         reset         = c.rstv;
         bus.OP        = c.op;
         bus.Zero      = c.zero;
         bus.mem_ready = c.rdy;
         @(negedge clk);
         checkVal(tag, 32'(obsWord()), 32'(c.exp));
         if (bus.InstrDone) obsDone++;
      end

      checkVal("doneCount", 32'(obsDone), 32'(expDone));
      $display("Result: errors=%0d of %0d checks", errCnt, checkCnt);
      $finish;
   end

endmodule
